// File: rtl/serdes_deser_1to8.sv
// serdes_deser_1to8: serial-to-parallel deserializer with bitslip word alignment
module serdes_deser_1to8 #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_Q = '0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CE,
  input  logic                  D,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  VALID,
  output logic                  SLIP_ACK
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
    $error("serdes_deser_1to8: DATA_WIDTH %0d outside 2..8", DATA_WIDTH);
  end
  logic [DATA_WIDTH-1:0] sr_q, sr_d, q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, ack_q, ack_d, pend_q, pend_d, bs_q, wrap;
  // a slip holds the counter for one bit, so the word boundary moves one bit later
  always_comb begin
    sr_d = !CE ? sr_q : MSB_FIRST ? {sr_q[DATA_WIDTH-2:0], D} : {D, sr_q[DATA_WIDTH-1:1]};
    wrap = CE && !pend_q && cnt_q == LAST;
    cnt_d = (!CE || pend_q) ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    q_d = wrap ? sr_d : q_q;
    valid_d = wrap;
    ack_d = CE && pend_q;
    pend_d = pend_q ? !CE : BITSLIP && !bs_q;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sr_q <= '0;
      cnt_q <= '0;
      q_q <= INIT_Q;
      valid_q <= 1'b0;
      ack_q <= 1'b0;
      pend_q <= 1'b0;
      bs_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      valid_q <= valid_d;
      ack_q <= ack_d;
      pend_q <= pend_d;
      bs_q <= BITSLIP;
    end
  end
  assign Q = q_q;
  assign VALID = valid_q;
  assign SLIP_ACK = ack_q;
endmodule

// File: tb/tb_serdes_deser_1to8.sv
// tb_serdes_deser_1to8: directed stimulus with an event scoreboard checked by a monitor
module tb_serdes_deser_1to8;
  typedef struct {
    logic [1:0] k;
    logic [7:0] v;
    int c;
  } ev_t;
  logic CLK = 1'b0;
  logic RSTN, CE, D, BITSLIP, VALID, SLIP_ACK;
  logic [7:0] Q;
  logic rstnb, ceb, db, valid_b, ack_b;
  logic [3:0] q_b;
  ev_t sb[$];
  ev_t m_e;
  logic [7:0] hold = 8'h96;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int nb = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  serdes_deser_1to8 #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .INIT_Q(8'h96)) u_a (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .D(D), .BITSLIP(BITSLIP),
    .Q(Q), .VALID(VALID), .SLIP_ACK(SLIP_ACK)
  );
  serdes_deser_1to8 #(.DATA_WIDTH(4), .MSB_FIRST(1'b0), .INIT_Q(4'h0)) u_b (
    .CLK(CLK), .RSTN(rstnb), .CE(ceb), .D(db), .BITSLIP(1'b0),
    .Q(q_b), .VALID(valid_b), .SLIP_ACK(ack_b)
  );
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic bit_(input logic d, input logic ce, input logic bs);
    D = d;
    CE = ce;
    BITSLIP = bs;
    @(posedge CLK);
    #1;
  endtask
  // k=1: VALID with word v, k=2: SLIP_ACK; expected after the edge just taken
  task automatic ev(input logic [1:0] k, input logic [7:0] v);
    sb.push_back('{k, v, cyc});
  endtask
  task automatic send_word(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_(v[i], 1'b1, 1'b0);
    ev(2'd1, v);
  endtask
  always @(negedge CLK) begin
    if (RSTN === 1'b1) begin
      if (VALID || SLIP_ACK) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event valid=%0b ack=%0b q=%h cyc=%0d", VALID, SLIP_ACK, Q, cyc);
        end else begin
          m_e = sb.pop_front();
          if ({VALID, SLIP_ACK} !== (m_e.k == 2'd1 ? 2'b10 : 2'b01) || m_e.c != cyc ||
              (m_e.k == 2'd1 && Q !== m_e.v)) begin
            errors++;
            $display("FAIL event got valid=%0b ack=%0b q=%h cyc=%0d exp kind=%0d q=%h cyc=%0d",
                     VALID, SLIP_ACK, Q, cyc, m_e.k, m_e.v, m_e.c);
          end
          if (m_e.k == 2'd1) hold = m_e.v;
        end
      end else begin
        checks++;
        if (Q !== hold) begin
          errors++;
          $display("FAIL q_hold got=%h exp=%h cyc=%0d", Q, hold, cyc);
        end
      end
    end
  end
  always @(negedge CLK) begin
    if (rstnb === 1'b1 && (valid_b || ack_b)) begin
      nb++;
      checks++;
      if (q_b !== 4'b0011 || ack_b !== 1'b0) begin
        errors++;
        $display("FAIL b_word got q=%b ack=%0b exp q=0011 ack=0", q_b, ack_b);
      end
    end
  end
  initial begin
    logic [24:0] sv;
    logic [12:0] tv;
    RSTN = 1'b0; CE = 1'b0; D = 1'b0; BITSLIP = 1'b0;
    rstnb = 1'b0; ceb = 1'b0; db = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_q", Q, 8'h96);
    chk("reset_valid", {7'd0, VALID}, 8'd0);
    chk("reset_ack", {7'd0, SLIP_ACK}, 8'd0);
    chk("b_reset_q", {4'd0, q_b}, 8'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    rstnb = 1'b1;
    send_word(8'hA5);
    send_word(8'h3C);
    for (int i = 7; i >= 0; i--) begin
      bit_(sv_bit(8'h5A, i), 1'b1, 1'b0);
      if (i != 0) bit_(~sv_bit(8'h5A, i), 1'b0, 1'b0);
    end
    ev(2'd1, 8'h5A);
    repeat (2) bit_(1'b1, 1'b0, 1'b0);
    sv = {1'b0, 24'hF0F0F0};
    for (int n = 0; n < 25; n++) begin
      bit_(sv[24-n], 1'b1, n == 7);
      if (n == 7) ev(2'd1, 8'h78);
      if (n == 8) ev(2'd2, 8'h00);
      if (n == 16 || n == 24) ev(2'd1, 8'hF0);
    end
    tv = {8'hF0, 5'b11110};
    for (int n = 0; n < 13; n++) begin
      bit_(tv[12-n], 1'b1, n >= 6 && n <= 10);
      if (n == 7) ev(2'd2, 8'h00);
      if (n == 8) ev(2'd1, 8'hE1);
    end
    #2;
    RSTN = 1'b0;
    hold = 8'h96;
    #1;
    chk("async_reset_q", Q, 8'h96);
    chk("async_reset_valid", {7'd0, VALID}, 8'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    send_word(8'hC3);
    repeat (3) bit_(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      db = (i < 2);
      ceb = 1'b1;
      @(posedge CLK);
      #1;
    end
    ceb = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("b_valid_count", 8'(nb), 8'd1);
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  function automatic logic sv_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction
endmodule

// File: doc/serdes_deser_1to8.md
Name: serdes_deser_1to8

Overview:
- Serial-to-parallel deserializer: the inverse direction of the wide-mux primitives in the Verilator-compatible Xilinx primitive library.
- Collects a 1-bit serial stream into DATA_WIDTH-bit words, with a bitslip control for word alignment.
- Behavioural stand-in for a simplified SDR ISERDES, used in Verilator simulation of LVDS/link receive front-ends.

Parameters:
- DATA_WIDTH, 8, word width; legal range 2..8; any other value is a $error at elaboration.
- MSB_FIRST, 1, 1: first received bit lands in Q[DATA_WIDTH-1]; 0: first received bit lands in Q[0].
- INIT_Q, 0, reset value of Q (DATA_WIDTH bits).

Ports:
- CLK  input  1  serial bit clock; all state updates on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- CE  input  1  clock enable; when 0, internal state and outputs hold, except the pulse outputs.
- D  input  1  serial data bit, sampled on each CE=1 edge.
- BITSLIP  input  1  level input; a 0->1 transition requests one bit of word-boundary slip.
- Q  output  DATA_WIDTH  last completed parallel word.
- VALID  output  1  one-cycle pulse: Q was updated at this edge.
- SLIP_ACK  output  1  one-cycle pulse: a slip request was consumed at this edge.

Behaviour:
- Reset (RSTN=0, async): shift register = 0, bit counter cnt = 0, Q = INIT_Q, VALID = 0, SLIP_ACK = 0, slip_pending = 0, BITSLIP edge register = 0. Reset mid-word discards partial bits; the first word after release is built from the first DATA_WIDTH CE=1 bits.
- BITSLIP edge detect: the previous-value register samples BITSLIP on every clock, independent of CE. A rising edge sets slip_pending. Further rising edges while slip_pending=1 are merged, not queued.
- Shift, on a CE=1 edge:
  - MSB_FIRST=1: sr <= {sr[W-2:0], D}.
  - MSB_FIRST=0: sr <= {D, sr[W-1:1]}.
  - D is shifted in on every CE=1 edge, including slip cycles.
- Counter, on a CE=1 edge:
  - slip_pending=1: cnt holds, slip_pending clears, SLIP_ACK=1 for this cycle, no word is emitted even if cnt==W-1. Net effect: the word boundary moves one bit later.
  - else if cnt==W-1: cnt <= 0, Q <= next sr value (including the current D), VALID=1.
  - else: cnt <= cnt+1.
- Latency: Q and VALID become visible after the edge that samples the W-th bit of a word. The first word is complete at the W-th CE edge after reset.
- CE=0 edge: sr, cnt, Q and slip_pending hold; VALID=0; SLIP_ACK=0. A BITSLIP rising edge during CE=0 is still captured into slip_pending.
- VALID and SLIP_ACK are each high for at most one cycle per event. They are never high together.
- Counter width is clog2(DATA_WIDTH). cnt wraps only via the W-1 -> 0 rule; no other wrap occurs.

Test Plan:
- W=8, MSB_FIRST=1: release reset, CE=1, send bits 1,0,1,0,0,1,0,1 -> VALID pulses at the 8th edge with Q=0xA5, and VALID=0 on all other edges.
- Back-to-back words 0xA5 then 0x3C, with no gap -> VALID at edges 8 and 16; Q=0xA5, then Q=0x3C.
- CE toggling 1,0,1,0 while sending 0x5A -> VALID only after the 8th CE=1 edge with Q=0x5A; Q holds across CE=0 cycles.
- Stream 0xF0 repeated, started one bit early (extra 0 first); pulse BITSLIP once -> SLIP_ACK pulses once, no VALID in that cycle; subsequent words read 0xF0.
- Hold BITSLIP high for 5 cycles -> exactly one SLIP_ACK. Slip landing on cnt==7 -> VALID deferred by one CE edge.
- Assert RSTN low after 4 bits of a word -> Q=INIT_Q and VALID=0 immediately. The next 8 bits form a clean word.
- MSB_FIRST=0, W=4: send bits 1,1,0,0 -> Q=4'b0011, VALID once.
